// File: rtl/mmio_fabric_pkg.sv
// Shared types and default constants for the MMIO fabric.
// The optional wait-state timeout is enabled by defining MMIO_FABRIC_TIMEOUT_EN.
package mmio_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } fabric_state_e;

    localparam int ERR_UNMAPPED = 0;
    localparam int ERR_TIMEOUT  = 1;

    localparam logic [23:0] DEFAULT_SLAVE_IDS = {4'h8, 4'h4, 4'h7, 4'h5, 4'h1, 4'h0};
    localparam logic [3:0]  DEFAULT_ERR_ID    = 4'hF;

    // Index width that stays legal for a single-slave build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_addr_decoder.sv
// Combinational selector decode: internal error register first, then the
// lowest-numbered channel whose ID matches.
module mmio_addr_decoder
    import mmio_fabric_pkg::*;
#(
    parameter int                         N_SLAVES  = 6,
    parameter int                         SEL_W     = 4,
    parameter logic [N_SLAVES*SEL_W-1:0]  SLAVE_IDS = DEFAULT_SLAVE_IDS,
    parameter logic [SEL_W-1:0]           ERR_ID    = DEFAULT_ERR_ID,
    parameter int                         IDX_W     = idx_width(N_SLAVES)
) (
    input  logic [SEL_W-1:0] sel,
    output logic             hit,
    output logic [IDX_W-1:0] idx,
    output logic             is_err_reg
);

    always_comb begin
        hit        = 1'b0;
        idx        = '0;
        is_err_reg = (sel == ERR_ID);
        if (!is_err_reg) begin
            // Walk downwards so the lowest matching index is the one kept.
            for (int i = N_SLAVES - 1; i >= 0; i--) begin
                if (SLAVE_IDS[i*SEL_W +: SEL_W] == sel) begin
                    hit = 1'b1;
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mmio_bus_fabric.sv
// Registered CPU-to-slave MMIO fabric with wait-state handshake and sticky errors.
// Define MMIO_FABRIC_TIMEOUT_EN to build the slave-response timeout counter.
module mmio_bus_fabric
    import mmio_fabric_pkg::*;
#(
    parameter int                         N_SLAVES  = 6,
    parameter int                         DATA_W    = 32,
    parameter int                         ADDR_W    = 32,
    parameter int                         SEL_W     = 4,
    parameter logic [N_SLAVES*SEL_W-1:0]  SLAVE_IDS = DEFAULT_SLAVE_IDS,
    parameter logic [SEL_W-1:0]           ERR_ID    = DEFAULT_ERR_ID,
    parameter int                         TIMEOUT   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_W-1:0]               cpu_addr,
    input  logic [DATA_W-1:0]               cpu_wdata,
    input  logic [DATA_W/8-1:0]             cpu_wstrb,
    input  logic                            cpu_rstrb,
    output logic [DATA_W-1:0]               cpu_rdata,
    output logic                            cpu_busy,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    output logic [N_SLAVES-1:0]             s_rstrb,
    output logic [N_SLAVES*(DATA_W/8)-1:0]  s_wstrb,
    input  logic [N_SLAVES*DATA_W-1:0]      s_rdata,
    input  logic [N_SLAVES-1:0]             s_ready,
    output logic                            err_irq
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(N_SLAVES);

    fabric_state_e                state_q, state_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [DATA_W-1:0]            wdata_q, wdata_d;
    logic                         is_write_q, is_write_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [N_SLAVES-1:0]          s_rstrb_q, s_rstrb_d;
    logic [N_SLAVES*STRB_W-1:0]   s_wstrb_q, s_wstrb_d;
    logic [DATA_W-1:0]            rdata_q, rdata_d;
    logic                         busy_q, busy_d;
    logic [1:0]                   err_q, err_d;
    logic [SEL_W-1:0]             err_sel_q, err_sel_d;

`ifdef MMIO_FABRIC_TIMEOUT_EN
    localparam int                CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0]             cnt_q, cnt_d;
`endif

    logic [SEL_W-1:0]  cpu_sel;
    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              dec_err_reg;
    logic              req;
    logic              wr;
    logic [DATA_W-1:0] err_reg_val;

    assign cpu_sel = cpu_addr[ADDR_W-1 -: SEL_W];
    assign wr      = |cpu_wstrb;
    assign req     = cpu_rstrb | wr;

    mmio_addr_decoder #(
        .N_SLAVES  (N_SLAVES),
        .SEL_W     (SEL_W),
        .SLAVE_IDS (SLAVE_IDS),
        .ERR_ID    (ERR_ID),
        .IDX_W     (IDX_W)
    ) u_decoder (
        .sel        (cpu_sel),
        .hit        (dec_hit),
        .idx        (dec_idx),
        .is_err_reg (dec_err_reg)
    );

    // Error register layout: selector of the last fault in [7:4], flags in [1:0].
    always_comb begin
        err_reg_val               = '0;
        err_reg_val[1:0]          = err_q;
        err_reg_val[4 +: SEL_W]   = err_sel_q;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        s_rstrb_d  = '0;
        s_wstrb_d  = '0;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        err_d      = err_q;
        err_sel_d  = err_sel_q;
`ifdef MMIO_FABRIC_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ACCESS: begin
                if (s_ready[idx_q]) begin
                    state_d = RESP;
                    busy_d  = 1'b0;
                    rdata_d = is_write_q ? '0 : s_rdata[idx_q*DATA_W +: DATA_W];
`ifdef MMIO_FABRIC_TIMEOUT_EN
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d            = RESP;
                    busy_d             = 1'b0;
                    rdata_d            = '0;
                    err_d[ERR_TIMEOUT] = 1'b1;
                    err_sel_d          = addr_q[ADDR_W-1 -: SEL_W];
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                // IDLE and RESP both accept a new request, giving back-to-back issue.
                state_d = IDLE;
                if (req) begin
                    addr_d     = cpu_addr;
                    wdata_d    = cpu_wdata;
                    is_write_d = wr;
                    idx_d      = dec_idx;
                    if (dec_err_reg) begin
                        state_d = RESP;
                        rdata_d = wr ? '0 : err_reg_val;
                        if (wr && cpu_wstrb[0]) begin
                            err_d     = '0;
                            err_sel_d = '0;
                        end
                    end else if (!dec_hit) begin
                        state_d             = RESP;
                        rdata_d             = '0;
                        err_d[ERR_UNMAPPED] = 1'b1;
                        err_sel_d           = cpu_sel;
                    end else begin
                        state_d = ACCESS;
                        busy_d  = 1'b1;
`ifdef MMIO_FABRIC_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                        if (wr) begin
                            s_wstrb_d[dec_idx*STRB_W +: STRB_W] = cpu_wstrb;
                        end else begin
                            s_rstrb_d[dec_idx] = 1'b1;
                        end
                    end
                end
            end
        endcase
`ifndef MMIO_FABRIC_TIMEOUT_EN
        err_d[ERR_TIMEOUT] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            s_rstrb_q  <= '0;
            s_wstrb_q  <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            err_q      <= '0;
            err_sel_q  <= '0;
`ifdef MMIO_FABRIC_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            s_rstrb_q  <= s_rstrb_d;
            s_wstrb_q  <= s_wstrb_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            err_sel_q  <= err_sel_d;
`ifdef MMIO_FABRIC_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_busy  = busy_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign s_rstrb   = s_rstrb_q;
    assign s_wstrb   = s_wstrb_q;
    assign err_irq   = |err_q;

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed bench for mmio_bus_fabric: decode, wait states, errors, back-to-back, reset.
module tb_mmio_bus_fabric;

    logic          clk;
    logic          rst;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [3:0]    cpu_wstrb;
    logic          cpu_rstrb;
    logic [31:0]   cpu_rdata;
    logic          cpu_busy;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [5:0]    s_rstrb;
    logic [23:0]   s_wstrb;
    logic [191:0]  s_rdata;
    logic [5:0]    s_ready;
    logic          err_irq;

    int total = 0;
    int bad   = 0;

    mmio_bus_fabric dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_rstrb (cpu_rstrb),
        .cpu_rdata (cpu_rdata),
        .cpu_busy  (cpu_busy),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rstrb   (s_rstrb),
        .s_wstrb   (s_wstrb),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready),
        .err_irq   (err_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_rstrb = 1'b0;
        cpu_wstrb = 4'h0;
    endtask

    initial begin
        rst       = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_wstrb = '0;
        cpu_rstrb = 1'b0;
        s_ready   = '0;
        s_rdata   = '0;
        s_rdata[0*32 +: 32] = 32'h1111_0000;
        s_rdata[1*32 +: 32] = 32'h0000_002A;
        s_rdata[2*32 +: 32] = 32'h0000_0077;
        s_rdata[4*32 +: 32] = 32'h0000_0055;

        // Reset values
        tick();
        tick();
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_busy", cpu_busy, 0);
        chk("rst_rstrb", s_rstrb, 0);
        chk("rst_wstrb", s_wstrb, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_swdata", s_wdata, 0);
        chk("rst_irq", err_irq, 0);
        rst = 1'b1;
        tick();

        // Zero-wait LED read
        s_ready   = 6'b000010;
        cpu_addr  = 32'h1000_0000;
        cpu_rstrb = 1'b1;
        tick();
        idle_inputs();
        chk("led_rstrb_c1", s_rstrb, 6'b000010);
        chk("led_busy_c1", cpu_busy, 1);
        chk("led_saddr_c1", s_addr, 32'h1000_0000);
        tick();
        chk("led_rdata_c2", cpu_rdata, 32'h2A);
        chk("led_busy_c2", cpu_busy, 0);
        chk("led_rstrb_c2", s_rstrb, 0);
        tick();

        // Unmapped read, then error-register read in the RESP cycle
        cpu_addr  = 32'h3000_0000;
        cpu_rstrb = 1'b1;
        tick();
        chk("unm_rdata", cpu_rdata, 0);
        chk("unm_irq", err_irq, 1);
        chk("unm_busy", cpu_busy, 0);
        chk("unm_rstrb", s_rstrb, 0);
        cpu_addr = 32'hF000_0000;
        tick();
        idle_inputs();
        chk("errreg_read", cpu_rdata, 32'h31);
        chk("errreg_busy", cpu_busy, 0);
        tick();

        // Clear error register
        cpu_addr  = 32'hF000_0000;
        cpu_wdata = 32'h1;
        cpu_wstrb = 4'h1;
        tick();
        idle_inputs();
        chk("clr_irq", err_irq, 0);
        chk("clr_rdata", cpu_rdata, 0);
        cpu_rstrb = 1'b1;
        tick();
        idle_inputs();
        chk("clr_readback", cpu_rdata, 0);
        tick();

        // Write with three wait states to channel 0
        s_ready   = 6'b000000;
        cpu_addr  = 32'h0000_0010;
        cpu_wdata = 32'hDEAD_BEEF;
        cpu_wstrb = 4'hF;
        tick();
        idle_inputs();
        chk("wr_wstrb_c1", s_wstrb, 24'h00000F);
        chk("wr_rstrb_c1", s_rstrb, 0);
        chk("wr_swdata_c1", s_wdata, 32'hDEAD_BEEF);
        chk("wr_busy_c1", cpu_busy, 1);
        tick();
        chk("wr_wstrb_c2", s_wstrb, 0);
        chk("wr_busy_c2", cpu_busy, 1);
        tick();
        chk("wr_busy_c3", cpu_busy, 1);
        tick();
        chk("wr_busy_c4", cpu_busy, 1);
        s_ready = 6'b000001;
        tick();
        chk("wr_busy_c5", cpu_busy, 0);
        chk("wr_rdata_c5", cpu_rdata, 0);
        s_ready = 6'b000000;
        tick();

        // Read and write strobes together act as a write
        s_ready   = 6'b000010;
        cpu_addr  = 32'h1000_0004;
        cpu_wdata = 32'h0000_00C3;
        cpu_rstrb = 1'b1;
        cpu_wstrb = 4'h3;
        tick();
        idle_inputs();
        chk("rw_rstrb", s_rstrb, 0);
        chk("rw_wstrb", s_wstrb, 24'h000030);
        tick();
        chk("rw_rdata", cpu_rdata, 0);
        chk("rw_busy", cpu_busy, 0);
        tick();

        // Silent UART slave
        s_ready   = 6'b000000;
        cpu_addr  = 32'h4000_0000;
        cpu_rstrb = 1'b1;
        tick();
        idle_inputs();
        chk("uart_rstrb_c1", s_rstrb, 6'b010000);
`ifdef MMIO_FABRIC_TIMEOUT_EN
        for (int k = 2; k <= 17; k++) tick();
        chk("to_busy_c17", cpu_busy, 1);
        chk("to_irq_c17", err_irq, 0);
        tick();
        chk("to_busy_c18", cpu_busy, 0);
        chk("to_rdata_c18", cpu_rdata, 0);
        chk("to_irq_c18", err_irq, 1);
        cpu_addr  = 32'hF000_0000;
        cpu_rstrb = 1'b1;
        tick();
        idle_inputs();
        chk("to_errreg", cpu_rdata, 32'h42);
        cpu_wdata = 32'h1;
        cpu_wstrb = 4'h1;
        tick();
        idle_inputs();
        chk("to_clr_irq", err_irq, 0);
`else
        for (int k = 2; k <= 30; k++) tick();
        chk("nto_busy_c30", cpu_busy, 1);
        chk("nto_irq_c30", err_irq, 0);
        s_ready = 6'b010000;
        tick();
        chk("nto_rdata", cpu_rdata, 32'h55);
        chk("nto_busy", cpu_busy, 0);
        s_ready = 6'b000000;
`endif
        tick();

        // Back-to-back zero-wait reads
        s_ready   = 6'b111111;
        cpu_addr  = 32'h0000_0000;
        cpu_rstrb = 1'b1;
        tick();
        idle_inputs();
        chk("b2b_rstrb_c1", s_rstrb, 6'b000001);
        tick();
        chk("b2b_rdata_c2", cpu_rdata, 32'h1111_0000);
        chk("b2b_busy_c2", cpu_busy, 0);
        cpu_addr  = 32'h1000_0000;
        cpu_rstrb = 1'b1;
        tick();
        idle_inputs();
        chk("b2b_rstrb_c3", s_rstrb, 6'b000010);
        chk("b2b_busy_c3", cpu_busy, 1);
        tick();
        chk("b2b_rdata_c4", cpu_rdata, 32'h2A);
        tick();

        // Reset during ACCESS, with a sticky error pending
        cpu_addr  = 32'h9000_0000;
        cpu_rstrb = 1'b1;
        tick();
        idle_inputs();
        chk("pre_rst_irq", err_irq, 1);
        s_ready   = 6'b000000;
        cpu_addr  = 32'h5000_0000;
        cpu_rstrb = 1'b1;
        tick();
        idle_inputs();
        chk("mid_rstrb", s_rstrb, 6'b000100);
        rst = 1'b0;
        tick();
        chk("mr_rstrb", s_rstrb, 0);
        chk("mr_busy", cpu_busy, 0);
        chk("mr_saddr", s_addr, 0);
        chk("mr_rdata", cpu_rdata, 0);
        chk("mr_irq", err_irq, 0);
        rst = 1'b1;
        tick();
        s_ready   = 6'b000100;
        cpu_addr  = 32'h5000_0000;
        cpu_rstrb = 1'b1;
        tick();
        idle_inputs();
        tick();
        chk("post_rst_rdata", cpu_rdata, 32'h77);
        chk("post_rst_busy", cpu_busy, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_bus_fabric.md
# mmio_bus_fabric

Parametrised memory-mapped interconnect between the single RISC-V CPU data port and N peripheral slaves (program memory, LED GPIOs, UART TX/RX, future devices). It replaces flat combinational address decoding with a registered request/response fabric. Slaves may insert wait states via a ready handshake. Unmapped accesses, and slaves that never respond when the timeout is compiled in, are reported through a sticky error register and an interrupt line.

## Interface
Parameters:
- N_SLAVES, 6: number of slave channels.
- DATA_W, 32: data width; strobe width is DATA_W/8.
- ADDR_W, 32: address width.
- SEL_W, 4: decode field width, taken from addr[ADDR_W-1 -: SEL_W].
- SLAVE_IDS, {4'h8,4'h4,4'h7,4'h5,4'h1,4'h0}: packed N_SLAVES×SEL_W selector values; channel i is the i-th field from LSB.
- ERR_ID, 4'hF: selector of the fabric's internal error register.
- TIMEOUT, 16: maximum wait cycles before a timeout error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- cpu_addr  in  ADDR_W  request address.
- cpu_wdata  in  DATA_W  write data.
- cpu_wstrb  in  DATA_W/8  byte write strobes; any bit set means a write.
- cpu_rstrb  in  1  read strobe.
- cpu_rdata  out  DATA_W  response data, registered.
- cpu_busy  out  1  high while a request is outstanding.
- s_addr  out  ADDR_W  latched address, broadcast to all slaves.
- s_wdata  out  DATA_W  latched write data, broadcast.
- s_rstrb  out  N_SLAVES  one-hot read strobe.
- s_wstrb  out  N_SLAVES×DATA_W/8  per-channel byte strobes.
- s_rdata  in  N_SLAVES×DATA_W  per-channel read data.
- s_ready  in  N_SLAVES  per-channel completion.
- err_irq  out  1  high while any sticky error bit is set.

## Operation
- States are IDLE, ACCESS and RESP.
- IDLE or RESP, request present (cpu_rstrb or |cpu_wstrb):
  - latch address, write data, strobes and decoded channel index;
  - go to ACCESS, or directly to RESP if the access is unmapped or targets ERR_ID.
- Read and write strobes in the same cycle: treated as a write; response data is 0.
- ACCESS:
  - first cycle drives the selected channel's s_rstrb/s_wstrb for exactly one cycle;
  - then waits for s_ready[idx]. s_ready sampled in the strobe cycle is valid (zero-wait slave).
- Response capture (going to RESP):
  - on s_ready, cpu_rdata <= s_rdata[idx] for reads, 0 for writes;
  - unmapped: cpu_rdata <= 0, set err[0];
  - timeout: cpu_rdata <= 0, set err[1].
- On any error, err_sel[7:4] <= faulting selector.
- RESP lasts one cycle, then returns to IDLE unless a new request is captured.
- Error register at ERR_ID:
  - read returns {24'b0, err_sel, 2'b0, err[1:0]};
  - write with cpu_wstrb[0] clears err and err_sel.
- Decode priority: ERR_ID first, then the lowest channel index on duplicate IDs.
- Requests arriving in ACCESS are ignored; the CPU does not issue while cpu_busy is high.

## Timing
- Reset values: state IDLE; cpu_rdata 0; cpu_busy 0; all s_rstrb/s_wstrb 0; s_addr 0; s_wdata 0; err 0; err_sel 0; err_irq 0.
- Zero-wait slave:
  - request in cycle 0;
  - strobe and busy in cycle 1;
  - cpu_rdata valid and busy low in cycle 2.
- Latency is 2 + wait states.
- Unmapped or ERR_ID access: 1-cycle latency, busy never asserted.
- Timeout: the wait counter resets on strobe and fires when it reaches TIMEOUT with no s_ready. Response comes TIMEOUT+2 cycles after the request.
- Back-to-back: a request presented in RESP is captured in that same cycle, giving no bubble.
- Reset mid-ACCESS: strobes drop the next edge, no response is produced, and err is cleared.

## Configuration
- MMIO_FABRIC_TIMEOUT_EN defined: wait counter built; timeout behaviour as above.
- Not defined:
  - no counter;
  - ACCESS waits on s_ready indefinitely;
  - err[1] is tied to 0.

## Structure
- Package mmio_fabric_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - error bit indices ERR_UNMAPPED=0 and ERR_TIMEOUT=1;
  - the default SLAVE_IDS and ERR_ID constants.
- One sub-module, mmio_addr_decoder: combinational selector → {hit, idx, is_err_reg}, parametrised on N_SLAVES, SEL_W, SLAVE_IDS, ERR_ID.

## Test plan
- Read of 0x1000_0000, LED slave s_ready tied high, s_rdata=0x2A → s_rstrb[1] pulses in cycle 1; cpu_rdata=0x0000_002A with busy low in cycle 2.
- Write 0xDEAD_BEEF with wstrb=4'hF to 0x0000_0010, slave ready after 3 waits → s_wstrb[0]=4'hF for one cycle, s_wdata=0xDEADBEEF, busy high for 4 cycles, cpu_rdata=0.
- Read of 0x3000_0000 (unmapped) → next cycle cpu_rdata=0, err_irq=1; a following read of 0xF000_0000 returns 0x0000_0031.
- MMIO_FABRIC_TIMEOUT_EN defined, UART slave (0x4…) never ready → response after 18 cycles, err[1] set. Writing 0x1 to 0xF000_0000 clears it; err_irq returns to 0.
- Back-to-back reads to 0x0… then 0x1… with zero-wait slaves → second request captured in the first RESP; responses in cycles 2 and 4.
- rst driven low during ACCESS → all outputs at reset values on the next edge; a subsequent normal read completes.
